// File: rtl/fadd_pipe_param.sv
// fadd_pipe_param: multi-cycle floating-point adder/subtractor with RNE rounding,
// flush-to-zero denormals, special-value handling and exception flags.
module fadd_pipe_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] operand1,
  input  logic [EXP_W+MAN_W:0] operand2,
  input  logic                 sub,
  input  logic                 input_ready,
  input  logic                 received,
  output logic [EXP_W+MAN_W:0] answer,
  output logic                 answer_ready,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic [2:0]           fsm_state
);
  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int XW        = MAN_W + 4;  // hidden bit + mantissa + guard/round/sticky
  localparam int EW        = EXP_W + 2;  // two's-complement working exponent
  localparam int LZW       = $clog2(XW);
  localparam int SHIFT_LIM = XW - 1;
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  // Handshake: input_ready is a request taken only in IDLE (one op in flight, no
  // queueing); answer_ready is held with answer/flags stable until received=1 is
  // seen in DONE, and drops on that same edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]    op_a, op_b;
  logic            l_sign, eff_sub, res_zero;
  logic [EW-1:0]   work_exp, norm_exp;
  logic [XW-1:0]   l_ext, s_ext, norm;
  logic [XW:0]     sum;

  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {a_sign, a_exp, a_man} = op_a;
  assign {b_sign, b_exp, b_man} = op_b;
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_man == '0);
  assign b_inf  = (&b_exp) && (b_man == '0);
  assign a_nan  = (&a_exp) && (a_man != '0);
  assign b_nan  = (&b_exp) && (b_man != '0);

  assign answer_ready = (state == S_DONE);
  assign busy         = (state != S_IDLE);
  assign fsm_state    = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (input_ready) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_DONE;
      S_DONE:  if (received) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Alignment: L is the larger magnitude, S is shifted right with a sticky tail.
  logic               swap, big_sign, big_zero, small_zero;
  logic [EXP_W-1:0]   big_exp, small_exp, d;
  logic [MAN_W-1:0]   big_man, small_man;
  logic [XW-1:0]      small_sig, aligned;
  logic [2*XW-2:0]    shift_win;

  always_comb begin
    swap       = ({b_exp, b_man} > {a_exp, a_man});
    big_sign   = swap ? b_sign : a_sign;
    big_exp    = swap ? b_exp : a_exp;
    big_man    = swap ? b_man : a_man;
    big_zero   = swap ? b_zero : a_zero;
    small_exp  = swap ? a_exp : b_exp;
    small_man  = swap ? a_man : b_man;
    small_zero = swap ? a_zero : b_zero;
    d          = big_exp - small_exp;
    small_sig  = small_zero ? '0 : {1'b1, small_man, 3'b000};
    shift_win  = {small_sig, {(XW-1){1'b0}}} >> d;
    if (int'(d) >= SHIFT_LIM)
      aligned = {{(XW-1){1'b0}}, ~small_zero};
    else
      aligned = {shift_win[2*XW-2:XW], shift_win[XW-1] | (|shift_win[XW-2:0])};
  end

  logic [LZW-1:0] lz;
  always_comb begin
    lz = '0;
    for (int i = 0; i < XW; i++)
      if (sum[i]) lz = LZW'(XW - 1 - i);
  end

  // Rounding and final packing, with special operands taking priority.
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] man_r;
  logic [EW-1:0]    exp_r;
  logic             g, r, st, up, inexact;
  logic [W-1:0]     rnd_answer;
  logic [3:0]       rnd_flags;

  always_comb begin
    mant    = norm[XW-1:3];
    g       = norm[2];
    r       = norm[1];
    st      = norm[0];
    up      = g & (r | st | mant[0]);
    mant_r  = {1'b0, mant} + (MAN_W+2)'(up);
    exp_r   = norm_exp + EW'(mant_r[MAN_W+1]);
    man_r   = mant_r[MAN_W+1] ? '0 : mant_r[MAN_W-1:0];
    inexact = g | r | st;
    rnd_answer = {l_sign, exp_r[EXP_W-1:0], man_r};
    rnd_flags  = {3'b000, inexact};
    if (!exp_r[EW-1] && exp_r >= EXP_MAX) begin
      rnd_answer = {l_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags  = 4'b0101;
    end else if (exp_r[EW-1] || exp_r == '0) begin
      rnd_answer = {l_sign, {(W-1){1'b0}}};
      rnd_flags  = 4'b0011;
    end
    if (res_zero) begin
      rnd_answer = {a_zero & b_zero & a_sign & b_sign, {(W-1){1'b0}}};
      rnd_flags  = 4'b0000;
    end
    if (a_nan || b_nan) begin
      rnd_answer = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      rnd_flags  = 4'b0000;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      rnd_answer = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      rnd_flags  = 4'b1000;
    end else if (a_inf) begin
      rnd_answer = op_a;
      rnd_flags  = 4'b0000;
    end else if (b_inf) begin
      rnd_answer = op_b;
      rnd_flags  = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      l_sign   <= 1'b0;
      eff_sub  <= 1'b0;
      work_exp <= '0;
      l_ext    <= '0;
      s_ext    <= '0;
      sum      <= '0;
      norm     <= '0;
      norm_exp <= '0;
      res_zero <= 1'b0;
      answer   <= '0;
      flags    <= '0;
    end else begin
      case (state)
        S_IDLE: if (input_ready) begin
          op_a <= operand1;
          op_b <= {operand2[W-1] ^ sub, operand2[W-2:0]};
        end
        S_ALIGN: begin
          l_sign   <= big_sign;
          eff_sub  <= a_sign ^ b_sign;
          work_exp <= EW'(big_exp);
          l_ext    <= big_zero ? '0 : {1'b1, big_man, 3'b000};
          s_ext    <= aligned;
        end
        S_ADD: sum <= eff_sub ? ({1'b0, l_ext} - {1'b0, s_ext})
                              : ({1'b0, l_ext} + {1'b0, s_ext});
        S_NORM: begin
          res_zero <= (sum == '0);
          if (sum[XW]) begin
            norm     <= {sum[XW:2], sum[1] | sum[0]};
            norm_exp <= work_exp + EW'(1);
          end else begin
            norm     <= sum[XW-1:0] << lz;
            norm_exp <= work_exp - EW'(lz);
          end
        end
        S_ROUND: begin
          answer <= rnd_answer;
          flags  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_pipe_param.sv
// Bench for fadd_pipe_param: single-precision and half-precision instances checked
// against an exact big-integer reference of the add/sub with RNE and flush-to-zero.
module tb_fadd_pipe_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand1, operand2, answer;
  logic        sub, input_ready, received, answer_ready, busy;
  logic [3:0]  flags;
  logic [2:0]  fsm_state;

  logic [15:0] h_op1, h_op2, h_answer;
  logic        h_sub, h_input_ready, h_received, h_answer_ready, h_busy;
  logic [3:0]  h_flags;
  logic [2:0]  h_fsm_state;

  int total = 0;
  int bad = 0;
  logic [35:0] exp_q[$];
  logic [19:0] h_exp_q[$];

  fadd_pipe_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .sub(sub),
    .input_ready(input_ready), .received(received), .answer(answer),
    .answer_ready(answer_ready), .flags(flags), .busy(busy), .fsm_state(fsm_state)
  );

  fadd_pipe_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .operand1(h_op1), .operand2(h_op2), .sub(h_sub),
    .input_ready(h_input_ready), .received(h_received), .answer(h_answer),
    .answer_ready(h_answer_ready), .flags(h_flags), .busy(h_busy), .fsm_state(h_fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Exact reference: operands become integers scaled by 2^-(bias+mw), summed
  // exactly, then rounded to mw+1 significant bits (ties to even).
  function automatic logic [35:0] ref_add(input int ew, input int mw,
      input logic [31:0] a, input logic [31:0] b, input logic s);
    int emax, ea, eb, p, e, sh;
    logic sa, sb, rs, inx, za, zb, ia, ib, na, nb;
    logic [31:0] ma, mb, mmask, inf_w, qnan_w;
    logic [299:0] va, vb, mag, kept, rem, half;
    emax   = (1 << ew) - 1;
    mmask  = (32'd1 << mw) - 32'd1;
    sa     = a[ew+mw];
    sb     = b[ew+mw] ^ s;
    ea     = int'((a >> mw) & 32'(emax));
    eb     = int'((b >> mw) & 32'(emax));
    ma     = a & mmask;
    mb     = b & mmask;
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
    na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
    inf_w  = 32'(emax) << mw;
    qnan_w = inf_w | (32'd1 << (mw - 1));
    if (na || nb) return {4'b0000, qnan_w};
    if (ia && ib && (sa != sb)) return {4'b1000, qnan_w};
    if (ia) return {4'b0000, (32'(sa) << (ew + mw)) | inf_w};
    if (ib) return {4'b0000, (32'(sb) << (ew + mw)) | inf_w};
    va = za ? '0 : (((300'd1 << mw) | 300'(ma)) << ea);
    vb = zb ? '0 : (((300'd1 << mw) | 300'(mb)) << eb);
    if (sa == sb) begin mag = va + vb; rs = sa; end
    else if (va >= vb) begin mag = va - vb; rs = sa; end
    else begin mag = vb - va; rs = sb; end
    if (mag == '0) return {4'b0000, 32'(za && zb && sa && sb) << (ew + mw)};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - mw;
    inx = 1'b0;
    if (p > mw) begin
      sh   = p - mw;
      kept = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      inx  = (rem != '0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 300'd1;
      if (kept[mw+1]) begin kept = kept >> 1; e = e + 1; end
    end else begin
      kept = mag << (mw - p);
    end
    if (e >= emax) return {4'b0101, (32'(rs) << (ew + mw)) | inf_w};
    if (e <= 0) return {4'b0011, 32'(rs) << (ew + mw)};
    return {3'b000, inx, (32'(rs) << (ew + mw)) | (32'(e) << mw) | (32'(kept) & mmask)};
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int emax, bias, e;
    logic [31:0] m;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    case ($urandom_range(0, 3))
      0:       e = int'($urandom_range(0, emax));
      1:       e = int'($urandom_range(0, 3));
      2:       e = emax - int'($urandom_range(0, 3));
      default: e = bias - 3 + int'($urandom_range(0, 6));
    endcase
    m = $urandom & ((32'd1 << mw) - 32'd1);
    if ($urandom_range(0, 7) == 0) m = '0;
    return (32'($urandom_range(0, 1)) << (ew + mw)) | (32'(e) << mw) | m;
  endfunction

  function automatic logic [31:0] near_op(input int ew, input int mw, input logic [31:0] a);
    int emax, e;
    logic [31:0] m;
    emax = (1 << ew) - 1;
    e = int'((a >> mw) & 32'(emax)) + int'($urandom_range(0, 2 * mw + 8)) - (mw + 4);
    if (e < 0) e = 0;
    if (e > emax) e = emax;
    m = $urandom & ((32'd1 << mw) - 32'd1);
    return (32'($urandom_range(0, 1)) << (ew + mw)) | (32'(e) << mw) | m;
  endfunction

  // Scoreboard: every cycle a result is presented it must equal the queue head.
  always @(negedge clk) begin
    if (!rst && answer_ready) begin
      if (exp_q.size() == 0) check("unexpected_answer", 1, 0);
      else begin
        check("answer_flags", {flags, answer}, exp_q[0]);
        if (received) void'(exp_q.pop_front());
      end
    end
    if (!rst && h_answer_ready) begin
      if (h_exp_q.size() == 0) check("h_unexpected_answer", 1, 0);
      else begin
        check("h_answer_flags", {h_flags, h_answer}, h_exp_q[0]);
        if (h_received) void'(h_exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
      input logic [35:0] expv, input int hold, input bit pulse);
    for (int w = 0; w < 50 && busy; w++) begin @(posedge clk); #1; end
    if (busy) begin check("idle_wait", busy, 0); return; end
    operand1 = a; operand2 = b; sub = s; input_ready = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    input_ready = 1'b0;
    check("busy_after_accept", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      if (pulse) begin
        operand1 = $urandom; operand2 = $urandom; sub = ~sub;
        input_ready = 1'b1; received = 1'(($urandom_range(0, 1)));
      end
      check("ready_during_compute", answer_ready, 0);
      @(posedge clk); #1;
    end
    input_ready = 1'b0;
    received = 1'b0;
    check("ready_at_latency4", answer_ready, 1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("ready_held", answer_ready, 1);
    end
    received = 1'b1;
    @(posedge clk); #1;
    received = 1'b0;
    check("ready_after_received", answer_ready, 0);
    check("busy_after_received", busy, 0);
  endtask

  task automatic run_op_h(input logic [15:0] a, input logic [15:0] b, input logic s,
      input logic [19:0] expv);
    for (int w = 0; w < 50 && h_busy; w++) begin @(posedge clk); #1; end
    if (h_busy) begin check("h_idle_wait", h_busy, 0); return; end
    h_op1 = a; h_op2 = b; h_sub = s; h_input_ready = 1'b1;
    h_exp_q.push_back(expv);
    @(posedge clk); #1;
    h_input_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("h_ready_at_latency4", h_answer_ready, 1);
    h_received = 1'b1;
    @(posedge clk); #1;
    h_received = 1'b0;
    check("h_busy_after_received", h_busy, 0);
  endtask

  logic [31:0] pin_a [12] = '{32'h3F800000, 32'h40400000, 32'h80000000, 32'h3F800000,
                              32'h3F800000, 32'h7F7FFFFF, 32'h00800001, 32'h7F800000,
                              32'h7FC00001, 32'h7F800000, 32'h3F800000, 32'hC0400000};
  logic [31:0] pin_b [12] = '{32'h40000000, 32'h40400000, 32'h80000000, 32'h33800000,
                              32'h33800001, 32'h7F7FFFFF, 32'h00800000, 32'hFF800000,
                              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic        pin_s [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b0};
  logic [35:0] pin_e [12] = '{36'h0_40400000, 36'h0_00000000, 36'h0_80000000, 36'h1_3F800000,
                              36'h1_3F800001, 36'h5_7F800000, 36'h3_00000000, 36'h8_7FC00000,
                              36'h0_7FC00000, 36'h0_7F800000, 36'h0_00000000, 36'h0_C0000000};

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [35:0] rm;
    rst = 1'b1;
    operand1 = '0; operand2 = '0; sub = 1'b0; input_ready = 1'b0; received = 1'b0;
    h_op1 = '0; h_op2 = '0; h_sub = 1'b0; h_input_ready = 1'b0; h_received = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_answer", answer, 0);
    check("rst_ready", answer_ready, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("h_rst_outputs", {h_answer, h_answer_ready, h_flags, h_busy}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      check($sformatf("model_pin%0d", i), ref_add(8, 23, pin_a[i], pin_b[i], pin_s[i]), pin_e[i]);
      run_op(pin_a[i], pin_b[i], pin_s[i], pin_e[i], (i == 5) ? 10 : 0, (i == 9));
    end

    // Reset in the middle of an operation discards it.
    operand1 = 32'h3F800000; operand2 = 32'h40000000; sub = 1'b0; input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    @(posedge clk); #1;
    check("busy_before_midrst", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_answer", answer, 0);
    check("midrst_ready", answer_ready, 0);
    check("midrst_flags", flags, 0);
    check("midrst_busy", busy, 0);
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_answer", answer_ready, 0);
    end
    run_op(32'h3F800000, 32'h40000000, 1'b0, 36'h0_40400000, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra = rand_op(8, 23);
      case ($urandom_range(0, 15))
        0:       rb = ra;
        1, 2, 3: rb = rand_op(8, 23);
        default: rb = near_op(8, 23, ra);
      endcase
      rs = 1'(($urandom_range(0, 1)));
      rm = ref_add(8, 23, ra, rb, rs);
      run_op(ra, rb, rs, rm, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    rm = ref_add(5, 10, 32'h3C00, 32'h4000, 1'b0);
    check("h_model_pin0", rm, 36'h0_00004200);
    run_op_h(16'h3C00, 16'h4000, 1'b0, 20'h0_4200);
    rm = ref_add(5, 10, 32'h7BFF, 32'h7BFF, 1'b0);
    check("h_model_pin1", rm, 36'h5_00007C00);
    run_op_h(16'h7BFF, 16'h7BFF, 1'b0, 20'h5_7C00);
    for (int n = 0; n < 100; n++) begin
      ra = rand_op(5, 10);
      rb = ($urandom_range(0, 3) == 0) ? rand_op(5, 10) : near_op(5, 10, ra);
      rs = 1'(($urandom_range(0, 1)));
      rm = ref_add(5, 10, ra, rb, rs);
      run_op_h(ra[15:0], rb[15:0], rs, {rm[35:32], rm[15:0]});
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("h_queue_drained", h_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_pipe_param.md
# fadd_pipe_param

Multi-cycle IEEE-754-style floating-point adder/subtractor with parametrised exponent and mantissa widths and a run-time add/sub mode. It extends the single-precision fadd handshake (input_ready / answer_ready / received) with round-to-nearest-even, special-value handling and exception flags. It sits between the core's FP register read and writeback and processes one operation at a time.

## Interface

- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 23: stored mantissa width (hidden bit implicit); word width W = 1+EXP_W+MAN_W
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- operand1  input  W  first operand {sign, exp, man}
- operand2  input  W  second operand
- sub  input  1  0: operand1+operand2; 1: operand1-operand2
- input_ready  input  1  operands valid; sampled only in IDLE
- received  input  1  consumer has taken answer; sampled only in DONE
- answer  output  W  result, stable while answer_ready=1
- answer_ready  output  1  result valid, held until received
- flags  output  4  {invalid, overflow, underflow, inexact}, valid with answer
- busy  output  1  high in every state except IDLE

## Operation

- States: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on input_ready=1, latch operand1, operand2 (sign of operand2 XOR sub) and go to ALIGN. input_ready in any other state is ignored (no queueing).
- ALIGN: classify operands. Exp=0 means zero (denormals flushed, man ignored). Exp all-ones with man=0 means inf; with man!=0 means NaN. Swap so L has larger magnitude ({exp,man} compare). Right-shift S mantissa (hidden bit included) by d=eL-eS into MAN_W+1 bits plus guard, round and sticky. If d >= MAN_W+3, S contributes only sticky (=1 if S nonzero).
- ADD: effective subtract when signs differ. Add or subtract on MAN_W+4 bits plus carry. L-S is never negative. Result sign = sign of L.
- NORM: on carry-out, shift right 1 (shifted-out bit ORed into sticky) and exp+1. Otherwise apply a leading-zero count and left shift, exp-lz. An exact zero result yields +0, except when both effective operands are -0, which yields -0.
- ROUND: RNE on guard/round/sticky; inexact = any of G|R|S. A mantissa carry from rounding increments exp. If exp >= all-ones: ±inf, overflow=1, inexact=1. If exp <= 0: signed zero, underflow=1, inexact=1.
- Specials override arithmetic at ROUND:
  - any NaN input -> canonical qNaN {0, all-ones, 1, 0...}, invalid=0;
  - inf + (-inf) effective -> canonical qNaN, invalid=1;
  - inf with finite -> that inf, flags 0.
- DONE: answer_ready=1, answer/flags held. received=1 -> IDLE on the next edge. received outside DONE is ignored.

## Timing

- Reset: answer=0, answer_ready=0, flags=0, busy=0, state=IDLE, all internal registers cleared.
- rst wins over every other input in any state, including mid-operation. Outputs read reset values after the edge where rst=1. The in-flight result is discarded.
- Latency: input_ready accepted at edge N; answer_ready=1 and answer valid after edge N+4 (state DONE).
- answer_ready stays 1 until the edge where received=1; it is 0 after that edge.
- Minimum issue interval is 6 cycles (accept, 4 compute, 1 DONE with received=1 immediately). Next accept is at the first IDLE cycle with input_ready=1.
- busy=1 from edge N through the edge that leaves DONE.

## Test plan

- 0x3F800000 + 0x40000000, sub=0 -> answer 0x40400000 after 4 edges, flags 0000; received same cycle -> IDLE next edge, busy=0.
- 0x40400000 - 0x40400000 (sub=1) -> 0x00000000, flags 0000. -0 + -0 (0x80000000 twice) -> 0x80000000.
- 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1. 0x3F800000 + 0x33800001 -> 0x3F800001, inexact=1.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 0101. 0x00800001 - 0x00800000 -> 0x00000000, flags 0011.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 1000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000, flags 0000. 0x7F800000 + 0x3F800000 -> 0x7F800000.
- Handshake/reset:
  - hold received=0 for 10 cycles in DONE -> answer and answer_ready stable;
  - pulse input_ready during ALIGN..ROUND -> ignored, result unchanged;
  - rst=1 during ADD -> next cycle all outputs 0, IDLE; fresh op then completes with correct result.
  - EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 -> 0x4200.
